// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit: size codes,
// FSM states, latched load context and store lane helpers.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] RST_VAL = 32'h0000_0000;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_e;

  // Fields of a granted load that must survive until its response arrives.
  typedef struct packed {
    logic [1:0] offset;
    logic [1:0] size;
    logic       is_unsigned;
  } load_ctx_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      SZ_BYTE: wd = {4{data[7:0]}};
      SZ_HALF: wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_formatter.sv
// Combinational load data formatter: lane select, width select and
// sign/zero extension of a little-endian bus word.
module load_formatter
  import mem_access_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;
  logic        sign_b;
  logic        sign_h;

  assign shifted = rdata_i >> {offset_i, 3'b000};
  assign sign_b  = ~unsigned_i & shifted[7];
  assign sign_h  = ~unsigned_i & shifted[15];

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    result_o = shifted;
    case (size_i)
      SZ_BYTE: result_o = {{24{sign_b}}, shifted[7:0]};
      SZ_HALF: result_o = {{16{sign_h}}, shifted[15:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: drives a req/gnt/rvalid bus, stalls the
// pipeline while a load is outstanding and formats returned load data.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  mem_size_in,
  input  logic        mem_unsigned_in,
  input  logic [31:0] ALU_out_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] Memory_Read_Data_out,
  output logic        mem_stall,
  output logic        misalign_exc,
  output logic        bus_error
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  load_ctx_t        ctx_q, ctx_d;
  logic             bus_error_q, bus_error_d;

  logic        access;
  logic        is_write;
  logic        misaligned;
  logic        in_idle;
  logic        in_wait;
  logic        timeout_hit;
  logic        load_done;
  logic        read_granted;
  logic [31:0] fmt_data;

  // Reads take priority when both controls are set.
  assign access     = MemRead_in | MemWrite_in;
  assign is_write   = MemWrite_in & ~MemRead_in;
  assign misaligned = access & is_misaligned(mem_size_in, ALU_out_in[1:0]);

  assign in_idle     = reset & (state_q == IDLE);
  assign in_wait     = reset & (state_q == WAIT_RSP);
  assign timeout_hit = in_wait & ~dmem_rvalid & (cnt_q == CNT_LAST);
  assign load_done   = in_wait & dmem_rvalid;

  assign dmem_req     = in_idle & access & ~misaligned;
  assign dmem_we      = dmem_req & is_write;
  assign dmem_addr    = {ALU_out_in[31:2], 2'b00};
  assign dmem_wdata   = store_wdata(mem_size_in, store_data_in);
  assign dmem_be      = dmem_req ? store_be(mem_size_in, ALU_out_in[1:0]) : 4'b0000;
  assign read_granted = dmem_req & dmem_gnt & ~dmem_we;

  assign misalign_exc = reset & misaligned;

  // A granted write retires in its grant cycle; a load releases the stall in
  // the cycle its data (or the timeout) arrives so MEM/WB captures it.
  assign mem_stall = (dmem_req & ~(dmem_gnt & dmem_we))
                   | (in_wait & ~dmem_rvalid & ~timeout_hit);

  load_formatter u_load_formatter (
    .offset_i   (ctx_q.offset),
    .size_i     (ctx_q.size),
    .unsigned_i (ctx_q.is_unsigned),
    .rdata_i    (dmem_rdata),
    .result_o   (fmt_data)
  );

  assign Memory_Read_Data_out = load_done ? fmt_data : RST_VAL;
  assign bus_error            = bus_error_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctx_d       = ctx_q;
    bus_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_granted) begin
          state_d = WAIT_RSP;
          cnt_d   = '0;
          ctx_d   = '{offset: ALU_out_in[1:0], size: mem_size_in, is_unsigned: mem_unsigned_in};
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          cnt_d       = '0;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ctx_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctx_q       <= ctx_d;
      bus_error_q <= bus_error_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised scoreboard bench for mem_access_stage: a driver issues MEM-stage
// accesses and plays the bus, a monitor checks every retirement and bus grant.
module tb_mem_access_stage;
  import mem_access_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_in, MemWrite_in, mem_unsigned_in;
  logic [1:0]  mem_size_in;
  logic [31:0] ALU_out_in, store_data_in;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] Memory_Read_Data_out;
  logic        mem_stall, misalign_exc, bus_error;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .MemRead_in           (MemRead_in),
    .MemWrite_in          (MemWrite_in),
    .mem_size_in          (mem_size_in),
    .mem_unsigned_in      (mem_unsigned_in),
    .ALU_out_in           (ALU_out_in),
    .store_data_in        (store_data_in),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_be              (dmem_be),
    .dmem_gnt             (dmem_gnt),
    .dmem_rvalid          (dmem_rvalid),
    .dmem_rdata           (dmem_rdata),
    .Memory_Read_Data_out (Memory_Read_Data_out),
    .mem_stall            (mem_stall),
    .misalign_exc         (misalign_exc),
    .bus_error            (bus_error)
  );

  typedef struct {
    logic [31:0] data;
    bit          mis;
    bit          tmo;
    int          stalls;
  } rsp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accesses as little-endian byte lists.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                             input int off, input logic [31:0] rd);
    longint v = 0;
    int     n = nbytes(sz);
    for (int i = 0; i < n; i++)
      v += longint'((rd >> (8 * (off + i))) & 32'hFF) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  function automatic bus_t model_store(input logic [1:0] sz, input logic [31:0] addr,
                                       input logic [31:0] sd, input bit we);
    bus_t b;
    int   n = nbytes(sz);
    int   o = int'(addr[1:0]);
    b.we    = we;
    b.addr  = addr & 32'hFFFF_FFFC;
    b.be    = '0;
    b.wdata = '0;
    for (int j = 0; j < 4; j++) begin
      b.be[j] = (j >= o) && (j < o + n);
      b.wdata[8*j +: 8] = sd[8*(j % n) +: 8];
    end
    return b;
  endfunction

  // Issue one instruction; g = request cycles before grant, k = wait cycle of rvalid.
  task automatic do_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] rdat, input int g, input int k);
    rsp_t r;
    int   n, o, reqc, wk;
    bit   granted_rd, done, mis;
    n   = nbytes(sz);
    o   = int'(addr[1:0]);
    mis = (o % n) != 0;
    r.mis    = mis;
    r.tmo    = rd && !mis && (k > T);
    r.data   = (rd && !mis && k <= T) ? model_load(sz, uns, o, rdat) : 32'h0;
    r.stalls = mis ? 0 : (rd ? g + ((k > T) ? T : k) : g);
    rsp_q.push_back(r);
    if (!mis) bus_q.push_back(model_store(sz, addr, sd, !rd));

    @(posedge clk); #1;
    MemRead_in = rd; MemWrite_in = wr; mem_size_in = sz; mem_unsigned_in = uns;
    ALU_out_in = addr; store_data_in = sd;
    reqc = 0; wk = 0; granted_rd = 0; done = 0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      if (granted_rd) wk++;
      dmem_rvalid = granted_rd && (wk == k);
      dmem_rdata  = dmem_rvalid ? rdat : $urandom;
      #1;
      if (dmem_req) begin
        dmem_gnt = (reqc == g);
        if (dmem_gnt && !dmem_we) granted_rd = 1;
        reqc++;
      end else begin
        dmem_gnt = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      done = !mem_stall;
    end
    check("op_retired", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      MemRead_in  = 0; MemWrite_in = 0;
      dmem_gnt    = 1'($urandom_range(0, 1));
      dmem_rvalid = (stray && i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      dmem_rdata  = $urandom;
    end
  endtask

  task automatic op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                    input logic [31:0] addr, input logic [31:0] sd,
                    input logic [31:0] rdat, input int g, input int k);
    do_op(rd, wr, sz, uns, addr, sd, rdat, g, k);
    idle((rd && k > T) ? 2 : $urandom_range(0, 2), rd && k > T);
  endtask

  // Reset while a load is outstanding; the late rvalid must be ignored.
  task automatic reset_in_wait();
    bus_t b;
    b = model_store(SZ_WORD, 32'h1001_0008, 32'h0, 1'b0);
    bus_q.push_back(b);
    @(posedge clk); #1;
    MemRead_in = 1; MemWrite_in = 0; mem_size_in = SZ_WORD; mem_unsigned_in = 0;
    ALU_out_in = 32'h1001_0008; dmem_rvalid = 0;
    #1 dmem_gnt = 1;
    @(posedge clk); #1;
    dmem_gnt = 0;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    reset = 1; MemRead_in = 0; dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("rst_wait_stall", 32'(mem_stall), 32'd0);
    check("rst_wait_data", Memory_Read_Data_out, 32'h0);
    @(posedge clk); #1;
    dmem_rvalid = 0;
  endtask

  // Monitor: retirements, bus grants, bus_error and reset-time outputs.
  initial begin
    rsp_t r;
    bus_t b;
    int   run;
    bit   err_pend;
    run = 0;
    err_pend = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_data", Memory_Read_Data_out, 32'h0);
        check("rst_misalign", 32'(misalign_exc), 32'd0);
        run = 0;
        err_pend = 0;
      end else begin
        check("bus_error", 32'(bus_error), 32'(err_pend));
        err_pend = 0;
        if (dmem_req && dmem_gnt) begin
          if (bus_q.size() == 0) begin
            check("bus_unexpected_grant", 32'd1, 32'd0);
          end else begin
            b = bus_q.pop_front();
            check("bus_we", 32'(dmem_we), 32'(b.we));
            check("bus_addr", dmem_addr, b.addr);
            if (b.we) begin
              check("bus_be", 32'(dmem_be), 32'(b.be));
              check("bus_wdata", dmem_wdata, b.wdata);
            end
          end
        end
        if (MemRead_in || MemWrite_in) begin
          if (mem_stall) begin
            run++;
          end else if (rsp_q.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            r = rsp_q.pop_front();
            check("load_data", Memory_Read_Data_out, r.data);
            check("misalign_exc", 32'(misalign_exc), 32'(r.mis));
            check("stall_cycles", 32'(run), 32'(r.stalls));
            err_pend = r.tmo;
            run = 0;
          end
        end else begin
          check("idle_data", Memory_Read_Data_out, 32'h0);
          check("idle_stall", 32'(mem_stall), 32'd0);
        end
      end
    end
  end

  initial begin
    bit          rd, wr;
    logic [31:0] a;
    reset = 0;
    MemRead_in = 1; MemWrite_in = 0; mem_size_in = SZ_WORD; mem_unsigned_in = 0;
    ALU_out_in = 32'h1001_0002; store_data_in = 0;
    dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    reset = 1; MemRead_in = 0; dmem_gnt = 0; dmem_rvalid = 0;
    idle(1, 0);

    op(1, 0, SZ_WORD, 0, 32'h1001_0004, 32'h0,        32'hDEAD_BEEF, 0, 3);
    op(1, 0, SZ_BYTE, 0, 32'h1001_0003, 32'h0,        32'h8011_2233, 0, 1);
    op(1, 0, SZ_BYTE, 1, 32'h1001_0003, 32'h0,        32'h8011_2233, 1, 2);
    op(1, 0, SZ_HALF, 0, 32'h1001_0002, 32'h0,        32'h8011_2233, 0, 1);
    op(1, 0, SZ_HALF, 1, 32'h1001_0000, 32'h0,        32'h8011_F233, 0, 2);
    op(0, 1, SZ_BYTE, 0, 32'h1001_0001, 32'h0000_00AB, 32'h0,        2, 1);
    op(0, 1, SZ_HALF, 0, 32'h1001_0002, 32'h1234_BEEF, 32'h0,        0, 1);
    op(0, 1, SZ_WORD, 0, 32'h1001_0008, 32'hA5A5_0F0F, 32'h0,        1, 1);
    op(1, 0, SZ_WORD, 0, 32'h1001_0002, 32'h0,        32'hFFFF_FFFF, 0, 1);
    op(0, 1, SZ_HALF, 0, 32'h1001_0001, 32'h0000_1234, 32'h0,        0, 1);
    op(1, 0, SZ_WORD, 0, 32'h1001_0010, 32'h0,        32'h1111_2222, 0, T + 3);
    op(1, 0, SZ_WORD, 0, 32'h1001_0014, 32'h0,        32'h3333_4444, 1, T);
    op(1, 1, 2'b11,   0, 32'h1001_0018, 32'h9999_9999, 32'h8765_4321, 0, 2);
    reset_in_wait();
    op(1, 0, SZ_BYTE, 0, 32'h1001_0001, 32'h0,        32'h0000_7F00, 0, 1);

    for (int i = 0; i < 200; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = $urandom;
      op(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom,
         $urandom, $urandom_range(0, 3), $urandom_range(1, T + 2));
    end

    idle(3, 0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit between the EX/MEM pipeline register and the MEM/WB register.
- Takes address (ALU result), store data and access controls, and drives a variable-latency data-memory bus with a req/gnt/rvalid handshake.
- Produces the formatted load data captured by MEM/WB, plus a stall that freezes the pipeline while an access is outstanding.
- Handles byte/halfword/word sizes (little-endian), misalignment and bus timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT_RSP before a bus error is declared.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
- MemRead_in  in  1  load instruction in MEM
- MemWrite_in  in  1  store instruction in MEM
- mem_size_in  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- mem_unsigned_in  in  1  1 = zero-extend load (lbu/lhu)
- ALU_out_in  in  32  byte address
- store_data_in  in  32  rt value for stores
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- Memory_Read_Data_out  out  32  formatted load data to MEM/WB
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
- misalign_exc  out  1  misaligned access this cycle (combinational)
- bus_error  out  1  one-cycle registered pulse on timeout

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, timeout counter=0, latched offset/size/unsigned=0, bus_error=0.
- While reset is low, dmem_req=0, mem_stall=0, Memory_Read_Data_out=0, misalign_exc=0.
- access = MemRead_in|MemWrite_in. If both are set, treat as a read.
- Misaligned: word with addr[1:0]!=0, or half with addr[0]!=0.
  - Sets misalign_exc=1; no bus request, no stall, store suppressed, read data 0.
- IDLE, aligned access:
  - Drives dmem_req=1 combinationally from the inputs. EX/MEM holds them stable while stalled.
  - dmem_we=MemWrite_in & ~MemRead_in.
  - mem_stall = dmem_req & ~(dmem_gnt & dmem_we): a granted write completes in its grant cycle.
  - Read granted: latch addr[1:0], size and unsigned; go to WAIT_RSP; clear counter.
- WAIT_RSP:
  - dmem_req=0, mem_stall=1 except in the completion cycle.
  - On dmem_rvalid: format dmem_rdata with the latched fields onto Memory_Read_Data_out, mem_stall=0 that cycle (MEM/WB captures at the edge), return to IDLE.
  - rvalid outside WAIT_RSP is ignored.
  - Otherwise increment the counter. When counter==TIMEOUT_CYCLES-1 with no rvalid: bus_error pulses next cycle, Memory_Read_Data_out=0, mem_stall=0 in that cycle, return to IDLE.
  - rvalid in the same cycle as the timeout wins (normal completion, no error).
- Store lanes:
  - byte: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}
  - half: be=addr[1]?1100:0011, wdata={2{data[15:0]}}
  - word: be=1111, wdata=data
- Load extraction: shift rdata right by 8*offset; take 8/16/32 bits; sign-extend unless unsigned.
- Memory_Read_Data_out=0 whenever no load completes this cycle.
- Gnt without req is ignored.
- Reset mid-WAIT_RSP: returns to IDLE; a late rvalid is ignored.
- Latency: write with immediate gnt = 0 stall cycles. Read = 1 (grant) + N wait cycles; stall deasserts in the rvalid cycle.

Decomposition:
- Shared pipeline package holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state enum {IDLE, WAIT_RSP}
  - reset value constant
- Sub-module load_formatter (combinational): offset, size, unsigned, rdata -> 32-bit result. Reused by any future MMIO path.

Test Plan:
- Aligned lw at 0x10010004, gnt same cycle, rvalid after 3 cycles with rdata 0xDEADBEEF -> stall high for 3 cycles, output 0xDEADBEEF in rvalid cycle.
- lb at 0x10010003 with rdata 0x80112233 -> 0xFFFFFF80; lbu same -> 0x00000080; lh at 0x...2 -> 0xFFFF8011.
- sb 0xAB at 0x10010001, gnt after 2 cycles -> be=0010, wdata=0xABABABAB, stall 2 cycles, none in grant cycle.
- lw at 0x10010002 -> misalign_exc=1, dmem_req=0, mem_stall=0; sh at 0x...1 -> no write issued.
- Read granted, no rvalid, TIMEOUT_CYCLES=4 -> stall released after 4 wait cycles, data 0, bus_error pulse 1 cycle; a later stray rvalid is ignored.
- reset driven low in WAIT_RSP -> next cycle IDLE, stall 0; rvalid arriving then does not change output.
